// File: rtl/mux_nto1_rr_reg_if.sv
// mux_nto1_rr_reg_if: per-channel input handshakes and tagged output handshake
interface mux_nto1_rr_reg_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = $clog2(CHANNELS);
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode_rr;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;
  modport master (
    output in_data, in_valid, mode_rr, sel, out_ready,
    input  in_ready, out, out_chan, out_valid
  );
  modport slave (
    input  in_data, in_valid, mode_rr, sel, out_ready,
    output in_ready, out, out_chan, out_valid
  );
endinterface

// File: rtl/mux_nto1_rr_reg.sv
// mux_nto1_rr_reg: N:1 registered mux, fixed-select or round-robin, tagged with source channel
module mux_nto1_rr_reg #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
) (
  input logic             clk,
  input logic             rst_n,
  mux_nto1_rr_reg_if.slave bus
);
  localparam int SEL_W = $clog2(CHANNELS);
  localparam int NP    = 1 << SEL_W;
  logic [NP-1:0]       w_vext;
  logic [NP*WIDTH-1:0] w_dext;
  logic [SEL_W-1:0]    w_rr_grant;
  logic                w_rr_ok;
  logic [SEL_W-1:0]    w_grant;
  logic                w_ok;
  logic                w_load_ok;
  logic                w_xfer;
  logic [SEL_W-1:0]    r_ptr;
  logic [WIDTH-1:0]    r_out;
  logic [SEL_W-1:0]    r_chan;
  logic                r_valid;
  // padding to a power of two makes sel >= CHANNELS see a zero valid bit
  assign w_vext    = NP'(bus.in_valid);
  assign w_dext    = (NP*WIDTH)'(bus.in_data);
  assign w_load_ok = !r_valid || bus.out_ready;
  always_comb begin
    w_rr_grant = '0;
    w_rr_ok    = 1'b0;
    for (int k = CHANNELS; k >= 1; k--)
      if (w_vext[SEL_W'((int'(r_ptr) + k) % CHANNELS)]) begin
        w_rr_grant = SEL_W'((int'(r_ptr) + k) % CHANNELS);
        w_rr_ok    = 1'b1;
      end
  end
  assign w_grant      = bus.mode_rr ? w_rr_grant : bus.sel;
  assign w_ok         = bus.mode_rr ? w_rr_ok : w_vext[bus.sel];
  assign w_xfer       = w_ok && w_load_ok;
  assign bus.in_ready = (w_xfer && rst_n) ? CHANNELS'(1) << w_grant : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out   <= '0;
      r_chan  <= '0;
      r_valid <= 1'b0;
      r_ptr   <= SEL_W'(CHANNELS - 1);
    end else if (w_xfer) begin
      r_out   <= w_dext[w_grant*WIDTH +: WIDTH];
      r_chan  <= w_grant;
      r_valid <= 1'b1;
      if (bus.mode_rr) r_ptr <= w_grant;
    end else if (bus.out_ready) begin
      r_valid <= 1'b0;
    end
  assign bus.out       = r_out;
  assign bus.out_chan  = r_chan;
  assign bus.out_valid = r_valid;
endmodule
